// File: rtl/crc_xb_check.sv
// ---------------------------------------------------------------------------
// crc_xb_check
//   Receive-side serial CRC checker for CRC_xb frames. A frame is BW payload
//   bits followed by CRC_BW CRC bits, delivered MSB first, one bit per
//   accepted transfer. The whole frame goes through a bit-serial long
//   division, and a zero remainder marks a good frame. The payload and the
//   received CRC field are captured and held until the next frame completes.
//   A saturating counter tracks frames that failed the check.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  in_bit / in_sop valid this cycle
//   in_bit    serial frame bit, MSB first
//   in_sop    first bit of a frame (qualified by in_valid)
//   in_ready  checker accepts a bit this cycle (low only in DONE)
//   done      one-cycle pulse: frame complete, result fields valid
//   crc_ok    last frame remainder was zero (held)
//   payload   last frame payload (held)
//   rx_crc    last frame CRC field (held)
//   aborted   one-cycle pulse: frame restarted by an in_sop mid-frame
//   busy      state is not IDLE
//   err_cnt   saturating count of frames with crc_ok = 0
// ---------------------------------------------------------------------------
module crc_xb_check #(
    parameter int                BW      = 40,
    parameter int                CRC_BW  = 8,
    parameter logic [CRC_BW-1:0] DIVISOR = 8'b0000_0111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              in_sop,
    output logic              in_ready,
    output logic              done,
    output logic              crc_ok,
    output logic [BW-1:0]     payload,
    output logic [CRC_BW-1:0] rx_crc,
    output logic              aborted,
    output logic              busy,
    output logic [15:0]       err_cnt
);

    localparam int TOTAL = BW + CRC_BW;
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] LAST_BIT = CW'(TOTAL);
    localparam logic [CW-1:0] LAST_PAY = CW'(BW);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    state_t            state;
    logic [CRC_BW-1:0] rem;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     pay_sr;
    logic [CRC_BW-1:0] crc_sr;

    logic              xfer;
    logic              start;
    logic              accept;
    logic [CRC_BW-1:0] rem_base;
    logic [CRC_BW-1:0] rem_next;
    logic [CW-1:0]     cnt_next;

    // Next-bit datapath. A start (sop from IDLE, or a restart inside RECV)
    // divides from a cleared remainder and reloads the counter to bit 1, so
    // an aborting sop bit is treated exactly like a fresh first bit. Bits
    // that arrive in IDLE without sop are consumed but never accepted into
    // the division.
    always_comb begin
        xfer     = in_valid & in_ready;
        start    = xfer & in_sop;
        accept   = xfer & ((state == RECV) | in_sop);
        rem_base = start ? '0 : rem;
        rem_next = {rem_base[CRC_BW-2:0], in_bit} ^ (rem_base[CRC_BW-1] ? DIVISOR : '0);
        cnt_next = start ? CW'(1) : cnt + CW'(1);
    end

    // Division, bit counter, capture shift registers and control FSM.
    // Result outputs are written only on the final-bit edge that also enters
    // DONE, so partial or aborted frames leave the held results untouched.
    // The final-bit crc_ok comes from rem_next so it reflects the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rem      <= '0;
            cnt      <= '0;
            pay_sr   <= '0;
            crc_sr   <= '0;
            in_ready <= 1'b1;
            done     <= 1'b0;
            crc_ok   <= 1'b0;
            payload  <= '0;
            rx_crc   <= '0;
            aborted  <= 1'b0;
            busy     <= 1'b0;
            err_cnt  <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;

            if (accept) begin
                rem <= rem_next;
                cnt <= cnt_next;
                if (cnt_next <= LAST_PAY) begin
                    pay_sr <= {pay_sr[BW-2:0], in_bit};
                end else begin
                    crc_sr <= {crc_sr[CRC_BW-2:0], in_bit};
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RECV;
                        busy  <= 1'b1;
                    end
                end
                RECV: begin
                    if (xfer) begin
                        if (in_sop) begin
                            aborted <= 1'b1;
                        end else if (cnt_next == LAST_BIT) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            crc_ok   <= (rem_next == '0);
                            payload  <= pay_sr;
                            rx_crc   <= {crc_sr[CRC_BW-2:0], in_bit};
                            if ((rem_next != '0) && (err_cnt != 16'hFFFF)) begin
                                err_cnt <= err_cnt + 16'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    cnt      <= '0;
                    rem      <= '0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
